// File: rtl/serializer_10b.sv
// 10-bit parallel-to-serial converter for an 8b/10b line.
// Sends a run of idle words after reset, then data or idle fill.
module serializer_10b #(
  parameter logic [9:0]  IDLE_WORD  = 10'h17C,
  parameter int unsigned INIT_IDLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enb,
  input  logic [9:0]  din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic        sout,
  output logic        sync,
  output logic        idle_flag,
  output logic [15:0] idle_cnt
);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  localparam logic [3:0] LAST_BIT  = 4'd9;
  localparam logic [3:0] LAST_INIT = 4'(INIT_IDLES - 1);

  state_t      state_q, state_d;
  logic [9:0]  shreg_q, shreg_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic [3:0]  init_cnt_q, init_cnt_d;
  logic        idle_flag_q, idle_flag_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;

  logic boundary;
  logic xfer;
  logic underrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      shreg_q     <= IDLE_WORD;
      bitcnt_q    <= 4'd0;
      init_cnt_q  <= 4'd0;
      idle_flag_q <= 1'b1;
      idle_cnt_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      init_cnt_q  <= init_cnt_d;
      idle_flag_q <= idle_flag_d;
      idle_cnt_q  <= idle_cnt_d;
    end
  end

  // Ready only at the last bit, so the reload never leaves a gap cycle.
  always_comb begin
    boundary  = enb && (bitcnt_q == LAST_BIT);
    din_ready = boundary &&
                ((state_q == ST_RUN) || (init_cnt_q == LAST_INIT));
    xfer      = din_valid && din_ready;
    underrun  = din_ready && !din_valid;
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bitcnt_d    = bitcnt_q;
    init_cnt_d  = init_cnt_q;
    idle_flag_d = idle_flag_q;
    idle_cnt_d  = idle_cnt_q;

    if (boundary) begin
      bitcnt_d = 4'd0;
      if (xfer) begin
        shreg_d     = din;
        idle_flag_d = 1'b0;
      end else begin
        shreg_d     = IDLE_WORD;
        idle_flag_d = 1'b1;
      end
      if (underrun && (idle_cnt_q != 16'hFFFF)) begin
        idle_cnt_d = idle_cnt_q + 16'd1;
      end
      if (state_q == ST_INIT) begin
        init_cnt_d = init_cnt_q + 4'd1;
        if (init_cnt_q == LAST_INIT) begin
          state_d = ST_RUN;
        end
      end
    end else if (enb) begin
      shreg_d  = {1'b0, shreg_q[9:1]};
      bitcnt_d = bitcnt_q + 4'd1;
    end
  end

  assign sout      = shreg_q[0];
  assign sync      = (bitcnt_q == 4'd0);
  assign idle_flag = idle_flag_q;
  assign idle_cnt  = idle_cnt_q;

endmodule

// File: tb/tb_serializer_10b.sv
// Bench for serializer_10b: directed words, per-word scoreboard
// on the serial stream plus cycle-level spot checks.
module tb_serializer_10b;

  logic        clk;
  logic        rst;
  logic        enb;
  logic [9:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic        sout;
  logic        sync;
  logic        idle_flag;
  logic [15:0] idle_cnt;

  serializer_10b dut (
    .clk       (clk),
    .rst       (rst),
    .enb       (enb),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .sout      (sout),
    .sync      (sync),
    .idle_flag (idle_flag),
    .idle_cnt  (idle_cnt)
  );

  localparam logic [9:0] IDLE = 10'h17C;

  typedef struct {
    logic [9:0]  w;
    logic        f;
    logic [15:0] c;
  } exp_t;

  exp_t exp_q[$];

  int          checks;
  int          failures;
  logic [15:0] exp_cnt;
  bit          mon_en;
  bit          adv;
  bit          radv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [9:0] w, input logic f,
                      input logic [15:0] c);
    exp_t e;
    e.w = w;
    e.f = f;
    e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    step();
    check("rst_sout", 32'(sout), 32'd0);
    check("rst_sync", 32'(sync), 32'd1);
    check("rst_ready", 32'(din_ready), 32'd0);
    check("rst_flag", 32'(idle_flag), 32'd1);
    check("rst_cnt", 32'(idle_cnt), 32'd0);
    rst = 1'b0;
    exp_cnt = 16'd0;
    for (int i = 0; i < 4; i++) push(IDLE, 1'b1, 16'd0);
  endtask

  // Waits for the next boundary, then offers a word or an idle slot.
  task automatic word_slot(input bit v, input logic [9:0] w,
                           output int waited);
    waited = 0;
    while (!din_ready && waited < 60) begin
      step();
      waited++;
    end
    if (!din_ready) begin
      check("ready_timeout", 32'(waited), 32'd0);
    end else begin
      din       = w;
      din_valid = v;
      if (v) begin
        push(w, 1'b0, exp_cnt);
      end else begin
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        push(IDLE, 1'b1, exp_cnt);
      end
      step();
    end
  endtask

  always @(posedge clk) begin
    adv  = enb || rst;
    radv = rst;
  end

  // Monitor: collect ten bits from each sync and compare to the queue.
  initial begin
    int          nb;
    logic [9:0]  cur;
    logic        cur_f;
    logic [15:0] cur_c;
    exp_t        e;
    nb = 0;
    cur = '0;
    cur_f = 1'b0;
    cur_c = '0;
    forever begin
      @(negedge clk);
      if (adv && mon_en) begin
        if (sync) begin
          if (nb != 0 && !radv) check("sync_early", 32'(nb), 32'd0);
          nb    = 0;
          cur_f = idle_flag;
          cur_c = idle_cnt;
        end else if (nb == 0) begin
          check("sync_missing", 32'(sync), 32'd1);
          nb = -1;
        end
        if (nb >= 0) begin
          cur[nb] = sout;
          nb++;
          if (nb == 10) begin
            nb = 0;
            if (exp_q.size() == 0) begin
              check("unexpected_word", 32'(cur), 32'h3FF);
            end else begin
              e = exp_q.pop_front();
              check("word", 32'(cur), 32'(e.w));
              check("word_flag", 32'(cur_f), 32'(e.f));
              check("word_cnt", 32'(cur_c), 32'(e.c));
            end
          end
        end else begin
          nb = 0;
        end
      end
    end
  end

  initial begin
    int         waited;
    logic [9:0] iw;
    logic [9:0] fw;
    checks    = 0;
    failures  = 0;
    exp_cnt   = 16'd0;
    mon_en    = 1'b1;
    adv       = 1'b0;
    radv      = 1'b0;
    rst       = 1'b1;
    enb       = 1'b1;
    din       = 10'd0;
    din_valid = 1'b0;
    iw        = IDLE;

    // Init idles, first ready at cycle 39, idle counted at edge 39
    step();
    do_reset();
    for (int c = 0; c < 40; c++) begin
      check("init_ready", 32'(din_ready), 32'(c == 39));
      check("init_sync", 32'(sync), 32'((c % 10) == 0));
      check("init_sout", 32'(sout), 32'(iw[c % 10]));
      if (c == 39) check("init_cnt39", 32'(idle_cnt), 32'd0);
      if (c < 39) step();
    end
    exp_cnt = 16'd1;
    push(IDLE, 1'b1, 16'd1);
    step();
    check("cnt_after_39", 32'(idle_cnt), 32'd1);

    // First data word at first ready, then back-to-back words
    do_reset();
    word_slot(1'b1, 10'h2AA, waited);
    check("init_len", 32'(waited), 32'd39);
    check("flag_data", 32'(idle_flag), 32'd0);
    word_slot(1'b1, 10'h17C, waited);
    word_slot(1'b1, 10'h283, waited);
    word_slot(1'b1, 10'h0FF, waited);
    check("cnt_b2b", 32'(idle_cnt), 32'd0);
    din_valid = 1'b0;
    word_slot(1'b0, 10'h000, waited);
    check("cnt_underrun", 32'(idle_cnt), 32'd1);

    // Freeze mid-word at bit 4
    fw = 10'h35A;
    word_slot(1'b1, fw, waited);
    din_valid = 1'b0;
    repeat (4) step();
    enb = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      check("frz_sout", 32'(sout), 32'(fw[4]));
      check("frz_sync", 32'(sync), 32'd0);
      check("frz_ready", 32'(din_ready), 32'd0);
    end
    enb = 1'b1;

    // Freeze at a boundary with a word pending
    repeat (5) step();
    check("bnd_ready", 32'(din_ready), 32'd1);
    din       = 10'h3C3;
    din_valid = 1'b1;
    enb       = 1'b0;
    #1;
    check("bnd_frz_ready", 32'(din_ready), 32'd0);
    step();
    check("bnd_frz_ready2", 32'(din_ready), 32'd0);
    enb = 1'b1;
    #1;
    check("bnd_resume", 32'(din_ready), 32'd1);
    push(10'h3C3, 1'b0, exp_cnt);
    step();
    din_valid = 1'b0;

    // Reset at bit 6 of a data word
    word_slot(1'b1, 10'h1F0, waited);
    din_valid = 1'b0;
    repeat (6) step();
    do_reset();
    word_slot(1'b1, 10'h0D5, waited);
    check("reinit_len", 32'(waited), 32'd39);
    din_valid = 1'b0;

    // Saturation of the underrun counter
    repeat (2) step();
    force dut.idle_cnt_q = 16'hFFFE;
    #1;
    release dut.idle_cnt_q;
    exp_cnt = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      word_slot(1'b0, 10'h000, waited);
      check("sat_cnt", 32'(idle_cnt), 32'hFFFF);
    end
    word_slot(1'b1, 10'h155, waited);
    din_valid = 1'b0;

    waited = 0;
    while (exp_q.size() != 0 && waited < 40) begin
      step();
      waited++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
